// File: rtl/eb_fifo.sv
// Elastic valid/ready FIFO stage: DEPTH entries, registered t_ready (no i_ready -> t_ready path),
// occupancy/almost-full report and synchronous flush.
module eb_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4,
    parameter int AFULL  = DEPTH - 1,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic [DWIDTH-1:0] t_data,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [DWIDTH-1:0] i_data,
    output logic              i_valid,
    input  logic              i_ready,
    input  logic              flush,
    output logic [CW-1:0]     count,
    output logic              almost_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              tr_q;
    logic              af_q;
    logic              push;
    logic              pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign t_ready     = tr_q & ~flush;
    assign i_valid     = (cnt != '0);
    assign push        = t_valid & t_ready;
    assign pop         = i_valid & i_ready;
    assign i_data      = mem[rp];
    assign count       = cnt;
    assign almost_full = af_q;

    always_comb begin
        cnt_next = cnt;
        if (flush) begin
            cnt_next = '0;
        end else if (push && !pop) begin
            cnt_next = cnt + CW'(1);
        end else if (!push && pop) begin
            cnt_next = cnt - CW'(1);
        end
    end

    // t_ready comes from the next occupancy, so a full buffer stays closed
    // for the cycle of a pop and reopens on the following one.
    always_ff @(posedge clk) begin
        if (!rstf) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            tr_q <= 1'b0;
            af_q <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tr_q <= (cnt_next != FULL_CNT);
            af_q <= (cnt_next >= AF_CNT);
            if (flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push) wp <= ptr_inc(wp);
                if (pop)  rp <= ptr_inc(rp);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstf && push) begin
            mem[wp] <= t_data;
        end
    end

endmodule
